// File: rtl/shift_arb_pkg.sv
// +--------------------------------------------------------------------------+
// | Module   : shift_arb_pkg                                                 |
// | Purpose  : Shared defaults and tag type for the shifter front-end arbiter|
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
`default_nettype none

package shift_arb_pkg;

    localparam int N_REQ_DEF    = 4;
    localparam int DATA_W_DEF   = 32;
    localparam int SHAMT_W_DEF  = 5;
    localparam int PIPE_LAT_DEF = 5;

    localparam int ID_W = $clog2(N_REQ_DEF);

    typedef struct packed {
        logic            valid;
        logic [ID_W-1:0] id;
    } tag_t;

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
// +--------------------------------------------------------------------------+
// | Module   : rr_arbiter                                                    |
// | Purpose  : Request vector to one-hot grant; round-robin pointer when     |
// |            SHIFT_ARB_RR_EN is defined, fixed lowest-index otherwise.     |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
`default_nettype none

module rr_arbiter
    import shift_arb_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF
) (
`ifdef SHIFT_ARB_RR_EN
    input  logic             clk,
    input  logic             reset,
`endif
    input  logic [N_REQ-1:0] req_valid,
    output logic [N_REQ-1:0] grant,
    output logic [ID_W-1:0]  grant_id,
    output logic             grant_any
);

`ifdef SHIFT_ARB_RR_EN
    logic [ID_W-1:0] ptr_q;
    logic [ID_W-1:0] ptr_d;
    logic [ID_W-1:0] idx;

    // Search begins at the pointer and wraps, so the last winner goes to the back.
    always_comb begin
        grant     = '0;
        grant_id  = '0;
        grant_any = 1'b0;
        idx       = '0;
        for (int off = 0; off < N_REQ; off++) begin
            idx = ID_W'((int'(ptr_q) + off) % N_REQ);
            if (!grant_any && req_valid[idx]) begin
                grant_any = 1'b1;
                grant_id  = idx;
            end
        end
        if (grant_any) begin
            grant[grant_id] = 1'b1;
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (grant_any) begin
            ptr_d = (grant_id == ID_W'(N_REQ - 1)) ? '0 : grant_id + ID_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    always_comb begin
        grant     = '0;
        grant_id  = '0;
        grant_any = |req_valid;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                grant_id = ID_W'(i);
            end
        end
        if (grant_any) begin
            grant[grant_id] = 1'b1;
        end
    end
`endif

endmodule

`default_nettype wire

// File: rtl/shift_arbiter.sv
// +--------------------------------------------------------------------------+
// | Module   : shift_arbiter                                                 |
// | Purpose  : Shares one pipelined barrel shifter among N_REQ requesters;   |
// |            SHIFT_ARB_RR_EN selects round-robin over fixed priority.      |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
`default_nettype none

module shift_arbiter
    import shift_arb_pkg::*;
#(
    parameter int N_REQ    = N_REQ_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int SHAMT_W  = SHAMT_W_DEF,
    parameter int PIPE_LAT = PIPE_LAT_DEF,
    parameter int IF_W     = $clog2(PIPE_LAT + 1)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [N_REQ-1:0]           req_valid,
    output logic [N_REQ-1:0]           req_ready,
    input  logic [N_REQ*DATA_W-1:0]    req_data,
    input  logic [N_REQ*SHAMT_W-1:0]   req_shamt,
    input  logic [N_REQ-1:0]           req_dir,
    output logic [DATA_W-1:0]          sh_I,
    output logic [SHAMT_W-1:0]         sh_S,
    output logic                       sh_R,
    input  logic [DATA_W-1:0]          sh_O,
    output logic [N_REQ-1:0]           resp_valid,
    output logic [DATA_W-1:0]          resp_data,
    output logic [IF_W-1:0]            inflight
);

    // The tag id width is fixed in the package, so N_REQ must agree with it.
    if ($clog2(N_REQ) != ID_W) begin : g_id_w_check
        $error("shift_arbiter: N_REQ does not match package ID_W");
    end

    logic [N_REQ-1:0] grant;
    logic [ID_W-1:0]  grant_id;
    logic             xfer;

    rr_arbiter #(
        .N_REQ     (N_REQ)
    ) u_arb (
`ifdef SHIFT_ARB_RR_EN
        .clk       (clk),
        .reset     (reset),
`endif
        .req_valid (req_valid),
        .grant     (grant),
        .grant_id  (grant_id),
        .grant_any (xfer)
    );

    assign req_ready = grant & {N_REQ{reset}};

    logic [DATA_W-1:0]  sh_i_q, sh_i_d;
    logic [SHAMT_W-1:0] sh_s_q, sh_s_d;
    logic               sh_r_q, sh_r_d;

    always_comb begin
        sh_i_d = '0;
        sh_s_d = '0;
        sh_r_d = 1'b0;
        if (xfer) begin
            sh_i_d = req_data[grant_id*DATA_W +: DATA_W];
            sh_s_d = req_shamt[grant_id*SHAMT_W +: SHAMT_W];
            sh_r_d = req_dir[grant_id];
        end
    end

    tag_t             tag_q [PIPE_LAT];
    tag_t             tag_d [PIPE_LAT];
    logic [N_REQ-1:0] resp_valid_q, resp_valid_d;
    logic [IF_W-1:0]  inflight_q, inflight_d;
    logic             done;

    always_comb begin
        tag_d[0].valid = xfer;
        tag_d[0].id    = grant_id;
        for (int i = 1; i < PIPE_LAT; i++) begin
            tag_d[i] = tag_q[i-1];
        end
    end

    // The response flop lines the tag up with sh_O, which trails the issue
    // register by PIPE_LAT edges; it is not counted as in flight.
    assign done = tag_q[PIPE_LAT-1].valid;

    always_comb begin
        resp_valid_d = '0;
        if (done) begin
            resp_valid_d[tag_q[PIPE_LAT-1].id] = 1'b1;
        end
    end

    always_comb begin
        inflight_d = inflight_q;
        if (xfer && !done) begin
            inflight_d = inflight_q + IF_W'(1);
        end else if (!xfer && done) begin
            inflight_d = inflight_q - IF_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sh_i_q       <= '0;
            sh_s_q       <= '0;
            sh_r_q       <= 1'b0;
            resp_valid_q <= '0;
            inflight_q   <= '0;
            for (int i = 0; i < PIPE_LAT; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            sh_i_q       <= sh_i_d;
            sh_s_q       <= sh_s_d;
            sh_r_q       <= sh_r_d;
            resp_valid_q <= resp_valid_d;
            inflight_q   <= inflight_d;
            for (int i = 0; i < PIPE_LAT; i++) begin
                tag_q[i] <= tag_d[i];
            end
        end
    end

    assign sh_I       = sh_i_q;
    assign sh_S       = sh_s_q;
    assign sh_R       = sh_r_q;
    assign resp_valid = resp_valid_q;
    assign resp_data  = sh_O;
    assign inflight   = inflight_q;

endmodule

`default_nettype wire

// File: tb/tb_shift_arbiter.sv
// Testbench for shift_arbiter: behavioural shifter plus a grant model and a
// response scoreboard keyed on the cycle each result is due.
`default_nettype none

module tb_shift_arbiter;

    localparam int N_REQ    = 4;
    localparam int DATA_W   = 32;
    localparam int SHAMT_W  = 5;
    localparam int PIPE_LAT = 5;
    localparam int IF_W     = $clog2(PIPE_LAT + 1);
`ifdef SHIFT_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic                     clk = 1'b0;
    logic                     reset = 1'b1;
    logic [N_REQ-1:0]         req_valid;
    logic [N_REQ-1:0]         req_ready;
    logic [N_REQ*DATA_W-1:0]  req_data;
    logic [N_REQ*SHAMT_W-1:0] req_shamt;
    logic [N_REQ-1:0]         req_dir;
    logic [DATA_W-1:0]        sh_I;
    logic [SHAMT_W-1:0]       sh_S;
    logic                     sh_R;
    logic [DATA_W-1:0]        sh_O;
    logic [N_REQ-1:0]         resp_valid;
    logic [DATA_W-1:0]        resp_data;
    logic [IF_W-1:0]          inflight;

    always #5 clk = ~clk;

    shift_arbiter #(
        .N_REQ    (N_REQ),
        .DATA_W   (DATA_W),
        .SHAMT_W  (SHAMT_W),
        .PIPE_LAT (PIPE_LAT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_data   (req_data),
        .req_shamt  (req_shamt),
        .req_dir    (req_dir),
        .sh_I       (sh_I),
        .sh_S       (sh_S),
        .sh_R       (sh_R),
        .sh_O       (sh_O),
        .resp_valid (resp_valid),
        .resp_data  (resp_data),
        .inflight   (inflight)
    );

    function automatic logic [DATA_W-1:0] shift_fn(logic [DATA_W-1:0] d, logic [SHAMT_W-1:0] s, logic r);
        return r ? (d >> s) : (d << s);
    endfunction

    // Shifter stand-in: result appears PIPE_LAT edges after its inputs change.
    logic [DATA_W-1:0] sh_pipe [PIPE_LAT];
    initial for (int i = 0; i < PIPE_LAT; i++) sh_pipe[i] = '0;
    always @(posedge clk) begin
        sh_pipe[0] <= shift_fn(sh_I, sh_S, sh_R);
        for (int i = 1; i < PIPE_LAT; i++) sh_pipe[i] <= sh_pipe[i-1];
    end
    assign sh_O = sh_pipe[PIPE_LAT-1];

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    typedef struct {
        int                id;
        logic [DATA_W-1:0] data;
        int                due;
    } exp_t;

    exp_t              sb[$];
    int                cyc = 0;
    int                m_ptr = 0;
    int                peak = 0;
    logic [N_REQ-1:0]  fired = '0;
    logic [DATA_W+SHAMT_W:0] exp_issue = '0;

    logic [DATA_W-1:0]  data_v  [N_REQ];
    logic [SHAMT_W-1:0] shamt_v [N_REQ];
    logic               dir_v   [N_REQ];
    int                 rem     [N_REQ];

    function automatic int pick(logic [N_REQ-1:0] v, int p);
        for (int off = 0; off < N_REQ; off++) begin
            if (v[(p + off) % N_REQ]) return (p + off) % N_REQ;
        end
        return -1;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    int               m_cnt;
    int               m_gi;
    logic [N_REQ-1:0] m_eg;
    logic [N_REQ-1:0] m_erv;

    always @(negedge clk) begin
        if (!reset) begin
            check("rst_ready", 64'(req_ready), 64'(0));
            check("rst_resp", 64'(resp_valid), 64'(0));
            check("rst_inflight", 64'(inflight), 64'(0));
            check("rst_issue", 64'({sh_R, sh_S, sh_I}), 64'(0));
            sb.delete();
            m_ptr     = 0;
            exp_issue = '0;
            fired     = '0;
        end else begin
            check("issue", 64'({sh_R, sh_S, sh_I}), 64'(exp_issue));
            m_erv = '0;
            if (sb.size() > 0 && sb[0].due == cyc) begin
                m_erv[sb[0].id] = 1'b1;
                check("resp_data", 64'(resp_data), 64'(sb[0].data));
                void'(sb.pop_front());
            end
            check("resp_valid", 64'(resp_valid), 64'(m_erv));
            m_cnt = 0;
            foreach (sb[k]) if (sb[k].due > cyc) m_cnt++;
            check("inflight", 64'(inflight), 64'(m_cnt));
            if (int'(inflight) > peak) peak = int'(inflight);
            m_gi = pick(req_valid, RR ? m_ptr : 0);
            m_eg = '0;
            if (m_gi >= 0) m_eg[m_gi] = 1'b1;
            check("req_ready", 64'(req_ready), 64'(m_eg));
            fired     = m_eg;
            exp_issue = '0;
            if (m_gi >= 0) begin
                sb.push_back('{id: m_gi,
                               data: shift_fn(data_v[m_gi], shamt_v[m_gi], dir_v[m_gi]),
                               due: cyc + 1 + PIPE_LAT});
                exp_issue = {dir_v[m_gi], shamt_v[m_gi], data_v[m_gi]};
                if (RR) m_ptr = (m_gi + 1) % N_REQ;
            end
        end
    end

    task automatic apply();
        for (int i = 0; i < N_REQ; i++) begin
            req_valid[i]                         = (rem[i] != 0);
            req_data[i*DATA_W +: DATA_W]         = data_v[i];
            req_shamt[i*SHAMT_W +: SHAMT_W]      = shamt_v[i];
            req_dir[i]                           = dir_v[i];
        end
    endtask

    task automatic new_op(input int i);
        data_v[i]  = $urandom;
        shamt_v[i] = SHAMT_W'($urandom_range(0, 31));
        dir_v[i]   = 1'($urandom_range(0, 1));
    endtask

    task automatic load(input int i, input logic [DATA_W-1:0] d, input logic [SHAMT_W-1:0] s,
                        input logic r, input int n);
        data_v[i]  = d;
        shamt_v[i] = s;
        dir_v[i]   = r;
        rem[i]     = n;
        apply();
    endtask

    // Granted requesters advance to their next operation or drop valid.
    task automatic tick();
        @(posedge clk);
        #1;
        for (int i = 0; i < N_REQ; i++) begin
            if (fired[i]) begin
                rem[i]--;
                if (rem[i] != 0) new_op(i);
            end
        end
        apply();
    endtask

    initial begin
        for (int i = 0; i < N_REQ; i++) begin
            data_v[i] = '0; shamt_v[i] = '0; dir_v[i] = 1'b0; rem[i] = 0;
        end
        apply();
        #2 reset = 1'b0;
        load(1, 32'hA5A5_0F0F, 5'd4, 1'b0, 1);
        repeat (3) tick();
        reset = 1'b1;
        repeat (8) tick();

        load(0, 32'h0000_10EE, 5'd1, 1'b1, 1);
        repeat (8) tick();
        load(2, 32'h0000_10EE, 5'd1, 1'b0, 1);
        repeat (8) tick();

        for (int i = 0; i < N_REQ; i++) begin
            new_op(i);
            rem[i] = 8;
        end
        apply();
        peak = 0;
        repeat (40) tick();
        check("peak_inflight", 64'(peak), 64'(PIPE_LAT));

        new_op(1); rem[1] = 6;
        new_op(3); rem[3] = 6;
        apply();
        repeat (20) tick();

        new_op(0);
        rem[0] = 3;
        apply();
        repeat (5) tick();
        reset = 1'b0;
        repeat (2) tick();
        reset = 1'b1;
        repeat (10) tick();
        load(3, 32'h8000_0001, 5'd31, 1'b1, 1);
        repeat (8) tick();

        repeat (10) tick();

        repeat (80) begin
            tick();
            for (int i = 0; i < N_REQ; i++) begin
                if (rem[i] == 0 && $urandom_range(0, 2) == 0) begin
                    new_op(i);
                    rem[i] = $urandom_range(1, 3);
                end
            end
            apply();
        end
        for (int i = 0; i < N_REQ; i++) rem[i] = 0;
        apply();
        repeat (10) tick();

        check("sb_drained", 64'(sb.size()), 64'(0));
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
